// File: rtl/traffic_sensor_frontend.sv
// Traffic sensor front end: synchronizes raw road detectors, keeps per-road
// saturating queue counts and qualifies the emergency-vehicle request.
`timescale 1ns/1ps
module traffic_sensor_frontend #(
    parameter int CNT_W    = 16,
    parameter int DEB_CYC  = 4,
    parameter int EMG_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       arr,
    input  logic [2:0]       dep,
    input  logic             emerg_req,
    input  logic             clr,
    output logic [CNT_W-1:0] traffic1,
    output logic [CNT_W-1:0] traffic2,
    output logic [CNT_W-1:0] traffic3,
    output logic             emerg,
    output logic [2:0]       ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [8:0]       DEB_LIM  = 9'(DEB_CYC);
    localparam logic [8:0]       HOLD_LIM = 9'(EMG_HOLD);

    typedef enum logic [1:0] {IDLE, QUAL, ACTIVE, HOLD} state_t;

    logic [2:0] arr_s1_reg, arr_s2_reg, arr_d_reg;
    logic [2:0] dep_s1_reg, dep_s2_reg, dep_d_reg;
    logic       req_s1_reg, req_s2_reg;
    logic [2:0] arr_ev, dep_ev;

    state_t     state_reg;
    logic [7:0] ctr_reg;
    logic [8:0] ctr_inc;
    logic       emerg_reg;

    logic [CNT_W-1:0] cnt_all [3];

    // Two synchronizer flops per raw input, plus a third stage for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arr_s1_reg <= '0;
            arr_s2_reg <= '0;
            arr_d_reg  <= '0;
            dep_s1_reg <= '0;
            dep_s2_reg <= '0;
            dep_d_reg  <= '0;
            req_s1_reg <= 1'b0;
            req_s2_reg <= 1'b0;
        end else begin
            arr_s1_reg <= arr;
            arr_s2_reg <= arr_s1_reg;
            arr_d_reg  <= arr_s2_reg;
            dep_s1_reg <= dep;
            dep_s2_reg <= dep_s1_reg;
            dep_d_reg  <= dep_s2_reg;
            req_s1_reg <= emerg_req;
            req_s2_reg <= req_s1_reg;
        end
    end

    assign arr_ev = arr_s2_reg & ~arr_d_reg;
    assign dep_ev = dep_s2_reg & ~dep_d_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_road
            logic [CNT_W-1:0] cnt_reg;
            logic             ovf_reg;

            // Simultaneous arrival and departure cancel; saturate at both ends.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (clr) begin
                    cnt_reg <= '0;
                    ovf_reg <= 1'b0;
                end else if (arr_ev[gi] && !dep_ev[gi]) begin
                    if (cnt_reg == CNT_MAX)
                        ovf_reg <= 1'b1;
                    else
                        cnt_reg <= cnt_reg + CNT_W'(1);
                end else if (dep_ev[gi] && !arr_ev[gi] && cnt_reg != '0) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                end
            end

            assign cnt_all[gi] = cnt_reg;
            assign ovf[gi]     = ovf_reg;
        end
    endgenerate

    assign traffic1 = cnt_all[0];
    assign traffic2 = cnt_all[1];
    assign traffic3 = cnt_all[2];

    assign ctr_inc = {1'b0, ctr_reg} + 9'd1;

    // emerg follows the state one cycle late; the shared counter debounces in
    // QUAL and times the release in HOLD.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            ctr_reg   <= 8'd0;
            emerg_reg <= 1'b0;
        end else begin
            emerg_reg <= (state_reg == ACTIVE) || (state_reg == HOLD);
            case (state_reg)
                IDLE: begin
                    if (req_s2_reg) begin
                        state_reg <= QUAL;
                        ctr_reg   <= 8'd1;
                    end
                end
                QUAL: begin
                    if (!req_s2_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        ctr_reg <= ctr_inc[7:0];
                        if (ctr_inc >= DEB_LIM)
                            state_reg <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!req_s2_reg) begin
                        state_reg <= HOLD;
                        ctr_reg   <= 8'd1;
                    end
                end
                HOLD: begin
                    if (req_s2_reg) begin
                        state_reg <= ACTIVE;
                    end else begin
                        ctr_reg <= ctr_inc[7:0];
                        if (ctr_inc >= HOLD_LIM)
                            state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign emerg = emerg_reg;

endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Bench for traffic_sensor_frontend: directed scenarios plus random traffic,
// compared every cycle against a sample-history reference model.
`timescale 1ns/1ps
module tb_traffic_sensor_frontend;

    localparam int CNT_W    = 4;
    localparam int DEB_CYC  = 4;
    localparam int EMG_HOLD = 8;
    localparam int CMAX     = (1 << CNT_W) - 1;
    localparam int DEB_LIM  = (DEB_CYC < 2) ? 2 : DEB_CYC;
    localparam int HOLD_LIM = (EMG_HOLD < 2) ? 2 : EMG_HOLD;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [2:0]       arr = '0;
    logic [2:0]       dep = '0;
    logic             emerg_req = 1'b0;
    logic             clr = 1'b0;
    logic [CNT_W-1:0] traffic1, traffic2, traffic3;
    logic             emerg;
    logic [2:0]       ovf;

    traffic_sensor_frontend #(
        .CNT_W(CNT_W), .DEB_CYC(DEB_CYC), .EMG_HOLD(EMG_HOLD)
    ) dut (
        .clk(clk), .rst(rst), .arr(arr), .dep(dep), .emerg_req(emerg_req),
        .clr(clr), .traffic1(traffic1), .traffic2(traffic2),
        .traffic3(traffic3), .emerg(emerg), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: raw samples per edge (newest first), counts, flags.
    logic [6:0] hist[$];
    int         cnt_m[3];
    logic [2:0] ovf_m;
    int         hi_run, lo_run;
    bit         active_m, emerg_m;

    function automatic void model_reset();
        hist     = '{7'd0, 7'd0, 7'd0, 7'd0};
        cnt_m    = '{0, 0, 0};
        ovf_m    = 3'b000;
        hi_run   = 0;
        lo_run   = 0;
        active_m = 1'b0;
        emerg_m  = 1'b0;
    endfunction

    // A count event at edge n comes from raw(n-2)=1 with raw(n-3)=0; the
    // request seen by the qualifier at edge n is raw(n-2).
    function automatic void model_step();
        logic [2:0] a_ev, d_ev;
        bit         r;
        hist.push_front({emerg_req, dep, arr});
        if (hist.size() > 4) void'(hist.pop_back());
        a_ev = hist[2][2:0] & ~hist[3][2:0];
        d_ev = hist[2][5:3] & ~hist[3][5:3];
        r    = hist[2][6];
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                cnt_m[i] = 0;
                ovf_m[i] = 1'b0;
            end else if (a_ev[i] && !d_ev[i]) begin
                if (cnt_m[i] == CMAX) ovf_m[i] = 1'b1;
                else cnt_m[i] = cnt_m[i] + 1;
            end else if (d_ev[i] && !a_ev[i] && cnt_m[i] > 0) begin
                cnt_m[i] = cnt_m[i] - 1;
            end
        end
        emerg_m = active_m;
        if (!active_m) begin
            hi_run = r ? hi_run + 1 : 0;
            if (hi_run >= DEB_LIM) begin
                active_m = 1'b1;
                lo_run   = 0;
            end
        end else begin
            lo_run = r ? 0 : lo_run + 1;
            if (lo_run >= HOLD_LIM) begin
                active_m = 1'b0;
                hi_run   = 0;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("check %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        else model_reset();
        @(negedge clk);
        cyc++;
        chk("traffic1", 32'(traffic1), 32'(cnt_m[0]));
        chk("traffic2", 32'(traffic2), 32'(cnt_m[1]));
        chk("traffic3", 32'(traffic3), 32'(cnt_m[2]));
        chk("ovf",      32'(ovf),      32'(ovf_m));
        chk("emerg",    32'(emerg),    32'(emerg_m));
    endtask

    task automatic pulse(input logic [2:0] a, input logic [2:0] d);
        arr = a;
        dep = d;
        tick();
        arr = '0;
        dep = '0;
        repeat (3) tick();
    endtask

    initial begin
        int   n;
        logic seen;
        int   glitch;
        model_reset();
        repeat (3) tick();
        lit("reset_traffic1", 32'(traffic1), 0);
        lit("reset_emerg", 32'(emerg), 0);
        rst = 1'b1;
        repeat (2) tick();

        repeat (5) pulse(3'b001, 3'b000);
        lit("arr5_traffic1", 32'(traffic1), 5);
        repeat (2) pulse(3'b000, 3'b001);
        lit("dep2_traffic1", 32'(traffic1), 3);
        lit("dep2_traffic2", 32'(traffic2), 0);
        lit("dep2_traffic3", 32'(traffic3), 0);

        repeat (7) pulse(3'b010, 3'b000);
        lit("arr7_traffic2", 32'(traffic2), 7);
        pulse(3'b010, 3'b010);
        lit("both_traffic2", 32'(traffic2), 7);
        pulse(3'b000, 3'b100);
        lit("dep_empty_traffic3", 32'(traffic3), 0);

        repeat (16) pulse(3'b100, 3'b000);
        lit("sat_traffic3", 32'(traffic3), 15);
        lit("sat_ovf", 32'(ovf), 4);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        lit("clr_traffic3", 32'(traffic3), 0);
        lit("clr_ovf", 32'(ovf), 0);

        emerg_req = 1'b1;
        repeat (3) tick();
        emerg_req = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            seen = seen | emerg;
        end
        lit("short_req_no_emerg", 32'(seen), 0);

        emerg_req = 1'b1;
        repeat (10) tick();
        lit("long_req_emerg", 32'(emerg), 1);
        emerg_req = 1'b0;
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (emerg == 1'b0) break;
        end
        lit("emerg_fall_cycles", 32'(n), 32'(EMG_HOLD + 3));
        repeat (4) tick();

        emerg_req = 1'b1;
        repeat (10) tick();
        emerg_req = 1'b0;
        glitch = 0;
        repeat (4) begin
            tick();
            if (emerg !== 1'b1) glitch++;
        end
        emerg_req = 1'b1;
        repeat (10) begin
            tick();
            if (emerg !== 1'b1) glitch++;
        end
        lit("hold_reassert_glitches", 32'(glitch), 0);
        emerg_req = 1'b0;
        repeat (15) tick();

        repeat (9) pulse(3'b001, 3'b000);
        lit("pre_rst_traffic1", 32'(traffic1), 9);
        emerg_req = 1'b1;
        repeat (8) tick();
        lit("pre_rst_emerg", 32'(emerg), 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        lit("async_rst_emerg", 32'(emerg), 0);
        lit("async_rst_traffic1", 32'(traffic1), 0);
        emerg_req = 1'b0;
        arr = 3'b111;
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();
        lit("post_rst_held_arr_traffic1", 32'(traffic1), 1);
        arr = '0;
        repeat (4) tick();

        for (int k = 0; k < 800; k++) begin
            arr = 3'($urandom);
            dep = (k < 300) ? 3'($urandom & $urandom & $urandom) : 3'($urandom);
            clr = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) emerg_req = ~emerg_req;
            tick();
        end
        clr = 1'b0;
        arr = '0;
        dep = '0;
        emerg_req = 1'b0;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_frontend.md
TRAFFIC_SENSOR_FRONTEND -- requirements
Module: traffic_sensor_frontend

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of each per-road vehicle count.
REQ-002 SHALL have parameter DEB_CYC, default 4: consecutive synchronized-high cycles needed to qualify an emergency request (legal range 1..255).
REQ-003 SHALL have parameter EMG_HOLD, default 8: cycles emerg stays asserted after the request drops (legal range 1..255).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port arr, input, 3: raw asynchronous vehicle-arrival detector per road; bit i is road i+1.
REQ-007 SHALL have port dep, input, 3: raw asynchronous vehicle-departure detector per road; bit i is road i+1.
REQ-008 SHALL have port emerg_req, input, 1: raw asynchronous emergency-vehicle request.
REQ-009 SHALL have port clr, input, 1: synchronous clear of all counts and overflow flags.
REQ-010 SHALL have ports traffic1, traffic2 and traffic3, outputs, CNT_W each: registered queue counts for roads 1, 2 and 3.
REQ-011 SHALL have port emerg, output, 1: registered, qualified emergency flag for the downstream light controller.
REQ-012 SHALL have port ovf, output, 3: sticky count-saturation flag per road.

Function
REQ-013 SHALL pass every arr, dep and emerg_req bit through its own 2-flop synchronizer before use.
REQ-014 SHALL detect rising edges on the synchronized arr and dep bits; one edge is one event, and a held-high level yields no further events.
REQ-015 SHALL update a count on the 3rd rising clk edge after the raw input is first sampled high (sync1, sync2, edge register).
REQ-016 SHALL, per road and per cycle, apply this priority: clr zeroes the count; arrival and departure events together leave it unchanged; arrival alone adds 1; departure alone subtracts 1.
REQ-017 SHALL saturate a count at 2^CNT_W-1; an arrival at that value leaves the count unchanged and sets ovf[i].
REQ-018 SHALL ignore a departure when the count is 0; the count never wraps below 0.
REQ-019 SHALL hold ovf[i] set until clr or reset clears it.
REQ-020 SHALL leave the emergency FSM unaffected by clr.
REQ-021 SHALL implement the emergency FSM states IDLE, QUAL, ACTIVE and HOLD, with one shared 8-bit counter.
REQ-022 SHALL, in IDLE, move to QUAL with counter=1 when synchronized req=1.
REQ-023 SHALL, in QUAL, return to IDLE when req=0; otherwise increment the counter and move to ACTIVE when the counter reaches DEB_CYC.
REQ-024 SHALL, in ACTIVE, stay while req=1 and move to HOLD with counter=1 when req=0.
REQ-025 SHALL, in HOLD, return to ACTIVE when req=1; otherwise increment the counter and move to IDLE when the counter reaches EMG_HOLD.
REQ-026 SHALL register emerg as 1 exactly in ACTIVE and HOLD, so emerg rises one cycle after the state enters ACTIVE.
REQ-027 SHALL, when DEB_CYC=1, go from IDLE to QUAL to ACTIVE on consecutive edges, with no extra bypass path.

Reset
REQ-028 SHALL, while rst=0, asynchronously force all synchronizer and edge flops to 0, traffic1/2/3=0, ovf=000, emerg=0, FSM=IDLE and counter=0.
REQ-029 SHALL, when rst asserts mid-operation (including in ACTIVE or HOLD), drop emerg immediately without waiting for the hold period.
REQ-030 SHALL register no edge event on the first cycle after rst deasserts, even if a raw input is already high.

Verification
REQ-031 SHALL cover: 5 separated arr[0] pulses, then 2 dep[0] pulses -> traffic1 reads 5, then 3; traffic2 and traffic3 stay 0.
REQ-032 SHALL cover: arr[1] and dep[1] rising in the same cycle with traffic2=7 -> traffic2 stays 7; dep[2] pulse with traffic3=0 -> traffic3 stays 0.
REQ-033 SHALL cover: with CNT_W=4, 16 arr[2] pulses -> traffic3=15 and ovf=100; then clr -> traffic3=0 and ovf=000.
REQ-034 SHALL cover: with DEB_CYC=4, emerg_req high for 3 cycles -> emerg never asserts; high for 10 cycles -> emerg=1, and it falls exactly EMG_HOLD+1 cycles after the synchronized req falls.
REQ-035 SHALL cover: emerg_req re-asserted during HOLD -> emerg stays 1 continuously with no glitch.
REQ-036 SHALL cover: rst pulled low while emerg=1 and traffic1=9 -> emerg=0 and traffic1=0 with no clk edge needed.
